// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32M opcode, state and width definitions
package riscv_pkg;

  localparam int XLEN = 32;

  // RV32M funct3 encodings
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2
  } state_e;

endpackage

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M multiply/divide unit
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start               request an operation (sampled only while idle)
//   funct3              RV32M opcode
//   operand_a/operand_b rs1/rs2 values from the register file
//   rd_in               destination register index
//   busy                operation in progress
//   done                one-cycle result-valid pulse
//   result              operation result, held until the next result
//   rd_out              destination index of the result
module mul_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);
  import riscv_pkg::*;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          f3_q, f3_d;
  logic [4:0]          rdl_q, rdl_d;     // rd captured at start
  logic [4:0]          rd_q, rd_d;       // rd presented with the result
  logic [XLEN-1:0]     res_q, res_d;
  logic [XLEN-1:0]     b_q, b_d;         // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]   acc_q, acc_d;     // product, or quotient in the low word
  logic [XLEN-1:0]     rem_q, rem_d;
  logic                neg_q, neg_d;     // negate the selected result in SIGN
  logic                spec_q, spec_d;   // special case, result preloaded in acc low word
  logic                done_q, done_d;

  // Operand decode at start
  logic            signed_a, signed_b, sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b, preload;
  logic            div_zero, div_ovf;

  assign signed_a = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                    (funct3 == F3_DIV)  || (funct3 == F3_REM);
  assign signed_b = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
  assign sign_a   = signed_a && operand_a[XLEN-1];
  assign sign_b   = signed_b && operand_b[XLEN-1];
  assign mag_a    = sign_a ? -operand_a : operand_a;
  assign mag_b    = sign_b ? -operand_b : operand_b;
  assign div_zero = funct3[2] && (operand_b == '0);
  assign div_ovf  = funct3[2] && !funct3[0] && (operand_a == MIN_NEG) && (operand_b == '1);
  // funct3[1] distinguishes remainder from quotient
  assign preload  = div_zero ? (funct3[1] ? operand_a : '1)
                             : (funct3[1] ? '0 : MIN_NEG);

  // One shift-add multiply step: multiplier bit is acc_q[0]
  logic [XLEN:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);

  // One restoring divide step: next dividend bit is acc_q[XLEN-1]
  logic [XLEN:0]   div_shift;
  logic            q_bit;
  logic [XLEN-1:0] div_diff;
  assign div_shift = {rem_q, acc_q[XLEN-1]};
  assign q_bit     = (div_shift >= {1'b0, b_q});
  // When q_bit is set the true difference is below the divisor, so XLEN bits suffice
  assign div_diff  = div_shift[XLEN-1:0] - b_q;

  // Sign correction
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = neg_q ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    rdl_d   = rdl_q;
    rd_d    = rd_q;
    res_d   = res_q;
    b_d     = b_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    neg_d   = neg_q;
    spec_d  = spec_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          f3_d    = funct3;
          rdl_d   = rd_in;
          cnt_d   = '0;
          rem_d   = '0;
          b_d     = mag_b;
          acc_d   = {{XLEN{1'b0}}, mag_a};
          neg_d   = (funct3[2] && funct3[1]) ? sign_a : (sign_a ^ sign_b);
          spec_d  = div_zero || div_ovf;
          if (div_zero || div_ovf) begin
            acc_d = {{XLEN{1'b0}}, preload};
          end
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (spec_q) begin
          // Preloaded result: pass straight through to SIGN
          state_d = S_SIGN;
        end else begin
          if (f3_q[2]) begin
            rem_d = q_bit ? div_diff : div_shift[XLEN-1:0];
            acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], q_bit};
          end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) begin
            state_d = S_SIGN;
          end
        end
      end
      S_SIGN: begin
        if (spec_q) begin
          res_d = acc_q[XLEN-1:0];
        end else begin
          case (f3_q)
            F3_MUL:                           res_d = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:     res_d = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:                  res_d = quo_fix;
            default:                          res_d = rem_fix;
          endcase
        end
        rd_d    = rdl_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      rdl_q   <= '0;
      rd_q    <= '0;
      res_q   <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      neg_q   <= 1'b0;
      spec_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      rdl_q   <= rdl_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      neg_q   <= neg_d;
      spec_q  <= spec_d;
      done_q  <= done_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = res_q;
  assign rd_out = rd_q;

endmodule
